// File: rtl/out_quant_fifo.sv
// out_quant_fifo: rounds and saturates a signed filter output to 16 bits,
// then buffers the quantized samples in a show-ahead FIFO with clip and
// overflow-drop counters. Outputs are all driven straight from registers.
module out_quant_fifo #(
  parameter int DIN_W = 19,
  parameter int SHIFT = 3,
  parameter int DEPTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [DIN_W-1:0] din,
  input  logic                    din_valid,
  output logic signed [15:0]      dout,
  output logic                    dout_valid,
  input  logic                    dout_ready,
  output logic                    full,
  output logic [7:0]              sat_cnt,
  output logic [7:0]              drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = DIN_W + 1;
  // Comparison width: wide enough for the sum and for the 16-bit limits.
  localparam int EW = (SW > 17) ? SW : 17;

  localparam logic signed [SW-1:0] RND   = SW'(1) << (SHIFT - 1);
  localparam logic signed [EW-1:0] MAX_V = EW'(32'sd32767);
  localparam logic signed [EW-1:0] MIN_V = EW'(-32'sd32768);
  localparam logic [CW-1:0]        DEPTH_C = CW'(DEPTH);

  // Stage 1 combinational path
  logic signed [SW-1:0] w_sum;
  logic signed [SW-1:0] w_shr;
  logic signed [EW-1:0] w_ext;
  logic                 w_hi;
  logic                 w_lo;
  logic signed [15:0]   w_sat;

  // Stage 1 registers
  logic signed [15:0]   r_q;
  logic                 r_q_valid;
  logic [7:0]           r_sat_cnt;

  // FIFO state
  logic signed [15:0]   r_mem [DEPTH];
  logic [AW-1:0]        r_wptr;
  logic [AW-1:0]        r_rptr;
  logic [CW-1:0]        r_count;
  logic signed [15:0]   r_dout;
  logic                 r_dout_valid;
  logic                 r_full;
  logic [7:0]           r_drop_cnt;

  // FIFO control
  logic                 w_pop;
  logic                 w_push;
  logic                 w_drop;
  logic [CW-1:0]        w_kept;
  logic [CW-1:0]        w_count_nxt;
  logic [AW-1:0]        w_rptr_nxt;
  logic signed [15:0]   w_dout_nxt;

  // Round half-up at SW bits (no wrap possible), arithmetic shift, then clip to 16 bits.
  always_comb begin
    w_sum = {din[DIN_W-1], din} + RND;
    w_shr = w_sum >>> SHIFT;
    w_ext = EW'(w_shr);
    w_hi  = (w_ext > MAX_V);
    w_lo  = (w_ext < MIN_V);
    if (w_hi) begin
      w_sat = 16'sh7FFF;
    end else if (w_lo) begin
      w_sat = 16'sh8000;
    end else begin
      w_sat = w_ext[15:0];
    end
  end

  // Stage 1 register: quantized sample, its valid flag and the clip counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_q       <= 16'sd0;
      r_q_valid <= 1'b0;
      r_sat_cnt <= 8'd0;
    end else begin
      r_q       <= w_sat;
      r_q_valid <= din_valid;
      if (din_valid && (w_hi || w_lo) && (r_sat_cnt != 8'hFF)) begin
        r_sat_cnt <= r_sat_cnt + 8'd1;
      end
    end
  end

  // Push/pop decisions and the look-ahead head value for the registered dout.
  always_comb begin
    w_pop  = r_dout_valid & dout_ready;
    w_push = r_q_valid & (~r_full | w_pop);
    w_drop = r_q_valid & ~w_push;
    w_kept = r_count - CW'(w_pop);
    w_count_nxt = w_kept + CW'(w_push);
    if (w_pop) begin
      w_rptr_nxt = r_rptr + AW'(1);
    end else begin
      w_rptr_nxt = r_rptr;
    end
    // When no old entry survives the edge, the new head is the one being written.
    if (w_count_nxt == CW'(0)) begin
      w_dout_nxt = 16'sd0;
    end else if (w_kept == CW'(0)) begin
      w_dout_nxt = r_q;
    end else begin
      w_dout_nxt = r_mem[w_rptr_nxt];
    end
  end

  // Storage array; contents are don't-care after reset because the pointers are cleared.
  always_ff @(posedge clk) begin
    if (!rst && w_push) begin
      r_mem[r_wptr] <= r_q;
    end
  end

  // FIFO pointers, occupancy, registered status/head and the drop counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr       <= AW'(0);
      r_rptr       <= AW'(0);
      r_count      <= CW'(0);
      r_dout       <= 16'sd0;
      r_dout_valid <= 1'b0;
      r_full       <= 1'b0;
      r_drop_cnt   <= 8'd0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + AW'(1);
      end
      r_rptr       <= w_rptr_nxt;
      r_count      <= w_count_nxt;
      r_dout       <= w_dout_nxt;
      r_dout_valid <= (w_count_nxt != CW'(0));
      r_full       <= (w_count_nxt == DEPTH_C);
      if (w_drop && (r_drop_cnt != 8'hFF)) begin
        r_drop_cnt <= r_drop_cnt + 8'd1;
      end
    end
  end

  assign dout       = r_dout;
  assign dout_valid = r_dout_valid;
  assign full       = r_full;
  assign sat_cnt    = r_sat_cnt;
  assign drop_cnt   = r_drop_cnt;

endmodule

// File: tb/tb_out_quant_fifo.sv
// Testbench for out_quant_fifo: directed scenarios plus a randomized run,
// all checked against a queue-based behavioural model of the block.
module tb_out_quant_fifo;

  localparam int DIN_W = 19;
  localparam int SHIFT = 3;
  localparam int DEPTH = 8;

  logic                    clk = 1'b0;
  logic                    rst;
  logic signed [DIN_W-1:0] din;
  logic                    din_valid;
  logic signed [15:0]      dout;
  logic                    dout_valid;
  logic                    dout_ready;
  logic                    full;
  logic [7:0]              sat_cnt;
  logic [7:0]              drop_cnt;

  int errors = 0;
  int checks = 0;

  // Behavioural model state
  int mq[$];
  bit m_pv;
  int m_pval;
  int m_sat;
  int m_drop;

  out_quant_fifo #(.DIN_W(DIN_W), .SHIFT(SHIFT), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .full(full), .sat_cnt(sat_cnt), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  // Round half-up of d / 2^SHIFT by floor division, then clip to int16.
  function automatic int quant(input int d, output bit clip);
    int div;
    int t;
    int q;
    div = 1 << SHIFT;
    t = d + div / 2;
    if (t >= 0) q = t / div;
    else q = -((-t + div - 1) / div);
    clip = 1'b0;
    if (q > 32767) begin q = 32767; clip = 1'b1; end
    if (q < -32768) begin q = -32768; clip = 1'b1; end
    return q;
  endfunction

  // One rising edge of the model, using the inputs the DUT samples at that edge.
  function automatic void model_step();
    bit pop;
    bit acc;
    bit c;
    int v;
    if (rst) begin
      mq.delete();
      m_pv = 1'b0; m_pval = 0; m_sat = 0; m_drop = 0;
    end else begin
      pop = (mq.size() != 0) && dout_ready;
      acc = m_pv && ((mq.size() < DEPTH) || pop);
      if (pop) void'(mq.pop_front());
      if (acc) mq.push_back(m_pval);
      else if (m_pv && m_drop < 255) m_drop++;
      v = quant(int'(din), c);
      m_pv = din_valid;
      m_pval = v;
      if (din_valid && c && m_sat < 255) m_sat++;
    end
  endfunction

  function automatic int exp_dout();
    return (mq.size() != 0) ? mq[0] : 0;
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; din_valid = 1'b0; dout_ready = 1'b0; din = '0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; din_valid = 1'b1; dout_ready = 1'b1; din = 19'sd40;
    tick();
    rst = 1'b0; din_valid = 1'b0;
    checks++;
    if (dout !== 16'sd0 || dout_valid !== 1'b0 || full !== 1'b0 || sat_cnt !== 8'd0 || drop_cnt !== 8'd0) begin
      errors++;
      $display("FAIL reset_state: dout=%0d valid=%b full=%b sat=%0d drop=%0d, required all 0",
               dout, dout_valid, full, sat_cnt, drop_cnt);
    end
    tick();
    tick();
    checks++;
    if (dout_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_inflight: dout_valid=%b, required 0", dout_valid);
    end
  endtask

  task automatic test_nominal();
    do_reset();
    dout_ready = 1'b1; din = 19'sd40; din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    checks++;
    if (dout_valid !== 1'b0) begin
      errors++;
      $display("FAIL nominal_k1: dout_valid=%b, required 0", dout_valid);
    end
    tick();
    checks++;
    if (dout_valid !== 1'b1 || dout !== 16'sd5 || sat_cnt !== 8'd0) begin
      errors++;
      $display("FAIL nominal_k2: valid=%b dout=%0d sat=%0d, required 1/5/0", dout_valid, dout, sat_cnt);
    end
    tick();
    checks++;
    if (dout_valid !== 1'b0 || dout !== 16'sd0) begin
      errors++;
      $display("FAIL nominal_k3: valid=%b dout=%0d, required 0/0", dout_valid, dout);
    end
  endtask

  task automatic test_rounding();
    int ins[5];
    int exp[5];
    int got[$];
    ins = '{4, 3, -4, -5, 12};
    exp = '{1, 0, 0, -1, 2};
    do_reset();
    dout_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      if (i < 5) begin din = DIN_W'(ins[i]); din_valid = 1'b1; end
      else din_valid = 1'b0;
      tick();
      if (dout_valid === 1'b1) got.push_back(int'(dout));
    end
    checks++;
    if (got.size() != 5) begin
      errors++;
      $display("FAIL rounding_count: got %0d outputs, required 5", got.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (got[i] != exp[i]) begin
          errors++;
          $display("FAIL rounding_%0d: dout=%0d, required %0d", i, got[i], exp[i]);
        end
      end
    end
  endtask

  task automatic test_saturation();
    do_reset();
    dout_ready = 1'b1;
    din = 19'sd262143; din_valid = 1'b1;
    tick();
    din = -19'sd262144;
    tick();
    din_valid = 1'b0;
    checks++;
    if (dout_valid !== 1'b1 || dout !== 16'sd32767 || sat_cnt !== 8'd1) begin
      errors++;
      $display("FAIL sat_pos: valid=%b dout=%0d sat=%0d, required 1/32767/1", dout_valid, dout, sat_cnt);
    end
    tick();
    checks++;
    if (dout_valid !== 1'b1 || dout !== -16'sd32768 || sat_cnt !== 8'd1) begin
      errors++;
      $display("FAIL sat_neg: valid=%b dout=%0d sat=%0d, required 1/-32768/1", dout_valid, dout, sat_cnt);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    dout_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      din = DIN_W'(8 * (i + 1)); din_valid = 1'b1;
      tick();
      if (i == 7) begin
        checks++;
        if (full !== 1'b0) begin
          errors++;
          $display("FAIL bp_not_full_yet: full=%b, required 0", full);
        end
      end
      if (i == 8) begin
        checks++;
        if (full !== 1'b1) begin
          errors++;
          $display("FAIL bp_full_after_8: full=%b, required 1", full);
        end
      end
    end
    din_valid = 1'b0;
    tick();
    checks++;
    if (full !== 1'b1 || drop_cnt !== 8'd2) begin
      errors++;
      $display("FAIL bp_drop: full=%b drop=%0d, required 1/2", full, drop_cnt);
    end
    dout_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (dout_valid !== 1'b1 || dout !== 16'(i + 1)) begin
        errors++;
        $display("FAIL bp_drain_%0d: valid=%b dout=%0d, required 1/%0d", i, dout_valid, dout, i + 1);
      end
      tick();
      if (i == 0) begin
        checks++;
        if (full !== 1'b0) begin
          errors++;
          $display("FAIL bp_full_fall: full=%b, required 0", full);
        end
      end
    end
    checks++;
    if (dout_valid !== 1'b0 || dout !== 16'sd0) begin
      errors++;
      $display("FAIL bp_empty: valid=%b dout=%0d, required 0/0", dout_valid, dout);
    end
  endtask

  task automatic test_full_pop();
    do_reset();
    dout_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      din = DIN_W'(8 * (i + 1)); din_valid = 1'b1;
      tick();
    end
    checks++;
    if (full !== 1'b1 || drop_cnt !== 8'd0) begin
      errors++;
      $display("FAIL fp_fill: full=%b drop=%0d, required 1/0", full, drop_cnt);
    end
    dout_ready = 1'b1;
    for (int j = 0; j < 16; j++) begin
      checks++;
      if (full !== 1'b1 || drop_cnt !== 8'd0 || dout_valid !== 1'b1 || dout !== 16'(j + 1)) begin
        errors++;
        $display("FAIL fp_stream_%0d: full=%b drop=%0d valid=%b dout=%0d, required 1/0/1/%0d",
                 j, full, drop_cnt, dout_valid, dout, j + 1);
      end
      din = DIN_W'(8 * (j + 10)); din_valid = 1'b1;
      tick();
    end
    din_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    dout_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      din = DIN_W'(8 * (i + 3)); din_valid = 1'b1;
      tick();
    end
    din_valid = 1'b0;
    tick();
    checks++;
    if (dout_valid !== 1'b1 || int'(dout) !== exp_dout() || mq.size() != 5) begin
      errors++;
      $display("FAIL rm_stored: valid=%b dout=%0d, required 1/%0d (5 entries)", dout_valid, dout, exp_dout());
    end
    rst = 1'b1; din_valid = 1'b1; dout_ready = 1'b1; din = 19'sd262143;
    tick();
    rst = 1'b0; din_valid = 1'b0;
    checks++;
    if (dout_valid !== 1'b0 || sat_cnt !== 8'd0 || drop_cnt !== 8'd0 || full !== 1'b0 || dout !== 16'sd0) begin
      errors++;
      $display("FAIL rm_after_rst: valid=%b sat=%0d drop=%0d full=%b dout=%0d, required all 0",
               dout_valid, sat_cnt, drop_cnt, full, dout);
    end
    din = 19'sd8; din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    checks++;
    if (dout_valid !== 1'b0) begin
      errors++;
      $display("FAIL rm_k1: valid=%b, required 0", dout_valid);
    end
    tick();
    checks++;
    if (dout_valid !== 1'b1 || dout !== 16'sd1) begin
      errors++;
      $display("FAIL rm_k2: valid=%b dout=%0d, required 1/1", dout_valid, dout);
    end
  endtask

  task automatic test_random();
    int r;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      r = int'($urandom_range(0, 99));
      rst = (r == 0);
      din_valid = ($urandom_range(0, 99) < 70);
      dout_ready = ($urandom_range(0, 99) < ((n / 100) % 2 == 0 ? 30 : 80));
      r = int'($urandom_range(0, 9));
      if (r == 0) din = 19'sd262143;
      else if (r == 1) din = -19'sd262144;
      else din = DIN_W'($urandom);
      tick();
      checks++;
      if (int'(dout) !== exp_dout() || dout_valid !== (mq.size() != 0) || full !== (mq.size() == DEPTH)
          || int'(sat_cnt) !== m_sat || int'(drop_cnt) !== m_drop) begin
        errors++;
        $display("FAIL random_%0d: dout=%0d valid=%b full=%b sat=%0d drop=%0d, required %0d/%b/%b/%0d/%0d",
                 n, dout, dout_valid, full, sat_cnt, drop_cnt, exp_dout(), (mq.size() != 0),
                 (mq.size() == DEPTH), m_sat, m_drop);
      end
    end
    rst = 1'b0; din_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; din = '0; din_valid = 1'b0; dout_ready = 1'b0;
    m_pv = 1'b0; m_pval = 0; m_sat = 0; m_drop = 0;
    #2;
    test_reset();
    test_nominal();
    test_rounding();
    test_saturation();
    test_backpressure();
    test_full_pop();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
